// File: rtl/addsub_sched_if.sv
// rtl/addsub_sched_if.sv - request/response bus between requesters and the add/sub scheduler
// Requester i occupies bit i of the per-requester vectors and [i*WIDTH +: WIDTH] of the operands.
interface addsub_sched_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ-1:0]       req_op;
  logic [N_REQ*WIDTH-1:0] req_x;
  logic [N_REQ*WIDTH-1:0] req_y;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [WIDTH-1:0]       rsp_result;
  logic                   rsp_carry;
  logic                   rsp_ovf;

  modport slave (
    input  req_valid, req_op, req_x, req_y, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_ovf
  );

  modport master (
    output req_valid, req_op, req_x, req_y, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_ovf
  );
endinterface

// File: rtl/addsub_sched.sv
// rtl/addsub_sched.sv - round-robin scheduler sharing one add/subtract datapath
// One operation in flight at a time: IDLE grants, EXEC computes, RESP holds the result.
module addsub_sched #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  addsub_sched_if.slave      bus
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW   = ID_W + 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              op_q;
  logic [WIDTH-1:0]  x_q, y_q;
  logic [ID_W-1:0]   id_q;
  logic              rsp_valid_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [WIDTH-1:0]  rsp_result_q;
  logic              rsp_carry_q;
  logic              rsp_ovf_q;

  logic              grant_found;
  logic [ID_W-1:0]   grant_id;
  logic              accept;

  logic [WIDTH-1:0]  b_op;
  logic [WIDTH:0]    sum_full;
  logic              carry_msb;

  // Search starts at rr_ptr and wraps, so the most recently served requester is checked last.
  always_comb begin
    logic [CW-1:0] idx;
    idx         = '0;
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, rr_ptr_q} + CW'(k);
      if (idx >= CW'(N_REQ)) begin
        idx = idx - CW'(N_REQ);
      end
      if (!grant_found && bus.req_valid[idx[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    accept        = 1'b0;
    bus.req_ready = '0;
    case (state_q)
      IDLE: begin
        // req_ready is gated by rst_n so it reads zero while reset is held.
        if (grant_found && rst_n) begin
          bus.req_ready[grant_id] = 1'b1;
          accept                  = 1'b1;
          state_d                 = EXEC;
          rr_ptr_d = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Subtraction is x + ~y + 1; the adder's carry-out is inverted to give a borrow.
  assign b_op      = op_q ? ~y_q : y_q;
  assign sum_full  = {1'b0, x_q} + {1'b0, b_op} + {{WIDTH{1'b0}}, op_q};
  assign carry_msb = x_q[WIDTH-1] ^ b_op[WIDTH-1] ^ sum_full[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      op_q         <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      id_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      if (accept) begin
        op_q <= bus.req_op[grant_id];
        x_q  <= bus.req_x[grant_id*WIDTH +: WIDTH];
        y_q  <= bus.req_y[grant_id*WIDTH +: WIDTH];
        id_q <= grant_id;
      end
      if (state_q == EXEC) begin
        rsp_valid_q  <= 1'b1;
        rsp_id_q     <= id_q;
        rsp_result_q <= sum_full[WIDTH-1:0];
        rsp_carry_q  <= sum_full[WIDTH] ^ op_q;
        rsp_ovf_q    <= carry_msb ^ sum_full[WIDTH];
      end else if (state_q == RESP && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_carry  = rsp_carry_q;
  assign bus.rsp_ovf    = rsp_ovf_q;
endmodule

// File: doc/addsub_sched.md
Name: addsub_sched

Overview:
- Round-robin scheduler that shares one 16-bit add/subtract datapath between N_REQ requesters.
- Each requester presents operands and an op code over a valid/ready handshake. The block grants one requester, registers its operands, computes the result and returns it with the requester id over a valid/ready response channel.
- Sits between client logic and the adder/subtractor datapath; it is the only owner of that datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8); ID_W = clog2(N_REQ).
- WIDTH, 16, operand/result width in bits.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept, one-hot or zero
- req_op  in  N_REQ  per-requester op: 0 = x+y, 1 = x-y
- req_x  in  N_REQ*WIDTH  operand x, requester i at [i*WIDTH +: WIDTH]
- req_y  in  N_REQ*WIDTH  operand y, same packing
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  ID_W  index of the requester served
- rsp_result  out  WIDTH  result
- rsp_carry  out  1  add: carry-out; sub: borrow (1 when x < y unsigned)
- rsp_ovf  out  1  signed two's-complement overflow

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - state = IDLE, rr_ptr = 0.
  - req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_result = 0, rsp_carry = 0, rsp_ovf = 0.
- States:
  - IDLE: waiting for a request.
  - EXEC: one cycle; computes and registers the result.
  - RESP: holds the response until the consumer accepts it.
- IDLE:
  - Grant = the first asserted req_valid searching from rr_ptr upward, wrapping modulo N_REQ.
  - req_ready[grant] = 1 combinationally, only in IDLE; all other bits are 0. No request means req_ready = 0 and the block stays in IDLE.
  - Request handshake completes on the edge where req_valid[i] & req_ready[i]. On that edge:
    - latch op, x, y and the id;
    - set rr_ptr = (grant+1) mod N_REQ;
    - go to EXEC.
- EXEC:
  - b = op ? ~y : y; {cout, sum} = x + b + op, computed at WIDTH+1 bits.
  - Register: rsp_result = sum, rsp_carry = cout ^ op, rsp_ovf = carry into MSB ^ cout.
  - Go to RESP and set rsp_valid = 1.
- RESP:
  - rsp_valid, rsp_id, rsp_result, rsp_carry and rsp_ovf stay stable until rsp_ready.
  - On the rsp_valid & rsp_ready edge: rsp_valid = 0, go to IDLE. Data outputs keep their last values.
- Latency: request accepted at edge t; rsp_valid high after edge t+1 (visible in cycle t+1..t+2); minimum issue interval 3 cycles.
- No new request is accepted while in EXEC or RESP (req_ready = 0). There is no back-to-back bypass.
- Requester contract: a requester must hold valid and data stable until accepted. The block does not check this.
- rr_ptr advances only on an accepted grant, never on idle cycles.
- Wrap-around: when the grant is N_REQ-1, rr_ptr becomes 0.
- rsp_ready held high permanently still gives exactly one rsp_valid cycle per request.
- Asynchronous reset in EXEC or RESP:
  - the in-flight operation is discarded;
  - all outputs go immediately to their reset values;
  - the next cycle after release is IDLE with rr_ptr = 0.

Test Plan:
- Reset then single add, requester 2: x=16'h7FFF, y=16'h0001, op=0.
  - req_ready = 4'b0100 in the same cycle.
  - Two cycles later rsp_valid=1, rsp_id=2, result=16'h8000, carry=0, ovf=1.
- Subtract with borrow, requester 0: x=16'h0003, y=16'h0005, op=1.
  - result=16'hFFFE, carry=1, ovf=0.
- All four requesters valid continuously, rsp_ready=1.
  - Grant order is 0,1,2,3,0,1; each grant is 3 cycles apart; rsp_id follows the same sequence.
- Back-pressure: rsp_ready=0 for 5 cycles after rsp_valid.
  - Outputs stay stable; req_ready stays 0 even with req_valid=4'b1111.
  - Raise rsp_ready: rsp_valid drops on the next edge and the next grant issues.
- Fairness after a partial round: requesters 1 and 3 valid, rr_ptr=2.
  - 3 is granted first, then 1; rr_ptr ends at 2.
- Reset mid-operation: assert rst_n=0 during EXEC.
  - rsp_valid=0 and all outputs reset immediately.
  - After release, requester 0 with 16'h0001+16'hFFFF gives result=16'h0000, carry=1, ovf=0, rsp_id=0.
